// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM states and bus-level constants.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    WR_DATA   = 3'd3,
    WR_ACK    = 3'd4,
    RD_DATA   = 3'd5,
    RD_ACK    = 3'd6,
    WAIT_STOP = 3'd7
  } state_t;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;
  localparam logic ACK   = 1'b0;
  localparam logic NACK  = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer for one raw bus line, followed by rise/fall detection
// on the synchronized level. SYNC_STAGES must be at least 2.
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_in;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign sync_in[gi] = din;
      end else begin : g_next
        assign sync_in[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  // An idle I2C bus is high, so flops reset to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '1;
      prev_reg <= 1'b1;
    end else begin
      sync_reg <= sync_in;
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign level = sync_reg[SYNC_STAGES-1];
  assign rise  = level & ~prev_reg;
  assign fall  = ~level & prev_reg;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: address match, write-byte receive, read-byte serve, open-drain SDA.
// All bus decisions are made on synchronized, edge-detected SCL/SDA.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h52,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       addressed,
  output logic [2:0] state
);

  logic scl_q, scl_rise, scl_fall;
  logic sda_q, sda_rise, sda_fall;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk(clk), .rst(rst), .din(scl_in), .level(scl_q), .rise(scl_rise), .fall(scl_fall)
  );
  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk(clk), .rst(rst), .din(sda_in), .level(sda_q), .rise(sda_rise), .fall(sda_fall)
  );

  logic start_det, stop_det;
  assign start_det = sda_fall & scl_q;
  assign stop_det  = sda_rise & scl_q;

  state_t     state_reg, state_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [6:0] shift_reg, shift_next;
  logic [7:0] tx_shift_reg, tx_shift_next;
  logic [7:0] rx_data_reg, rx_data_next;
  logic       sda_oe_reg, sda_oe_next;
  logic       addressed_reg, addressed_next;
  logic       rx_valid_reg, rx_valid_next;
  logic       tx_req_reg, tx_req_next;
  logic       rw_reg, rw_next;
  logic       ack_phase_reg, ack_phase_next;
  logic [7:0] rx_byte;

  assign rx_byte = {shift_reg, sda_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= 3'd0;
      shift_reg     <= 7'd0;
      tx_shift_reg  <= 8'd0;
      rx_data_reg   <= 8'h00;
      sda_oe_reg    <= 1'b0;
      addressed_reg <= 1'b0;
      rx_valid_reg  <= 1'b0;
      tx_req_reg    <= 1'b0;
      rw_reg        <= WRITE;
      ack_phase_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      tx_shift_reg  <= tx_shift_next;
      rx_data_reg   <= rx_data_next;
      sda_oe_reg    <= sda_oe_next;
      addressed_reg <= addressed_next;
      rx_valid_reg  <= rx_valid_next;
      tx_req_reg    <= tx_req_next;
      rw_reg        <= rw_next;
      ack_phase_reg <= ack_phase_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    tx_shift_next  = tx_shift_reg;
    rx_data_next   = rx_data_reg;
    sda_oe_next    = sda_oe_reg;
    addressed_next = addressed_reg;
    rx_valid_next  = 1'b0;
    tx_req_next    = 1'b0;
    rw_next        = rw_reg;
    ack_phase_next = ack_phase_reg;

    if (stop_det) begin
      state_next     = IDLE;
      bit_cnt_next   = 3'd0;
      sda_oe_next    = 1'b0;
      addressed_next = 1'b0;
    end else if (start_det) begin
      state_next     = ADDR;
      bit_cnt_next   = 3'd0;
      sda_oe_next    = 1'b0;
      addressed_next = 1'b0;
    end else begin
      case (state_reg)
        ADDR: if (scl_rise) begin
          shift_next   = rx_byte[6:0];
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            if (rx_byte[7:1] == SLAVE_ADDR) begin
              state_next     = ADDR_ACK;
              ack_phase_next = 1'b0;
              rw_next        = rx_byte[0];
              tx_req_next    = (rx_byte[0] == READ);
            end else begin
              state_next = WAIT_STOP;
            end
          end
        end
        // First fall presents the ACK; second fall hands SDA to the data phase.
        ADDR_ACK: if (scl_fall) begin
          if (!ack_phase_reg) begin
            sda_oe_next    = ~ACK;
            addressed_next = 1'b1;
            ack_phase_next = 1'b1;
          end else if (rw_reg == WRITE) begin
            sda_oe_next  = 1'b0;
            bit_cnt_next = 3'd0;
            state_next   = WR_DATA;
          end else begin
            sda_oe_next   = ~tx_data[7];
            tx_shift_next = {tx_data[6:0], 1'b0};
            bit_cnt_next  = 3'd0;
            state_next    = RD_DATA;
          end
        end
        WR_DATA: if (scl_rise) begin
          shift_next   = rx_byte[6:0];
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            rx_data_next   = rx_byte;
            rx_valid_next  = 1'b1;
            ack_phase_next = 1'b0;
            state_next     = WR_ACK;
          end
        end
        WR_ACK: if (scl_fall) begin
          if (!ack_phase_reg) begin
            sda_oe_next    = ~ACK;
            ack_phase_next = 1'b1;
          end else begin
            sda_oe_next  = 1'b0;
            bit_cnt_next = 3'd0;
            state_next   = WR_DATA;
          end
        end
        RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              ack_phase_next = 1'b0;
              state_next     = RD_ACK;
            end
          end else if (scl_fall) begin
            sda_oe_next   = ~tx_shift_reg[7];
            tx_shift_next = {tx_shift_reg[6:0], 1'b0};
          end
        end
        // ack_phase here means the master's ACK has been seen on the 9th rise.
        RD_ACK: begin
          if (scl_fall) begin
            if (!ack_phase_reg) begin
              sda_oe_next = 1'b0;
            end else begin
              sda_oe_next   = ~tx_data[7];
              tx_shift_next = {tx_data[6:0], 1'b0};
              bit_cnt_next  = 3'd0;
              state_next    = RD_DATA;
            end
          end else if (scl_rise && !ack_phase_reg) begin
            if (sda_q == NACK) begin
              sda_oe_next = 1'b0;
              state_next  = WAIT_STOP;
            end else begin
              tx_req_next    = 1'b1;
              ack_phase_next = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe    = sda_oe_reg;
  assign rx_data   = rx_data_reg;
  assign rx_valid  = rx_valid_reg;
  assign tx_req    = tx_req_reg;
  assign addressed = addressed_reg;
  assign state     = state_reg;

endmodule

// File: tb/tb_i2c_slave.sv
// Bus-level bench for i2c_slave: bit-banged master, directed table, hand corner
// sequences and randomized transfers checked against a transaction-level model.
module tb_i2c_slave;
  import i2c_pkg::*;

  localparam logic [6:0] SLAVE = 7'h52;

  logic       clk, rst;
  logic       scl_m, sda_m, sda_line;
  logic       sda_oe, rx_valid, tx_req, addressed;
  logic [7:0] rx_data, tx_data;
  logic [2:0] state;

  assign sda_line = sda_m & ~sda_oe;

  i2c_slave #(.SLAVE_ADDR(SLAVE), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(sda_line), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_req(tx_req), .tx_data(tx_data),
    .addressed(addressed), .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;
  int rx_cnt = 0, tx_cnt = 0, oe_cnt = 0, viol = 0;
  int tx_base = 0;
  logic [2:0][7:0] tx_bytes = '0;
  logic [7:0] exp_rx_data = 8'h00;

  // Pulse monitor; also plays the byte source answering tx_req.
  initial begin
    logic rx_prev, tx_prev;
    int   k;
    rx_prev = 1'b0;
    tx_prev = 1'b0;
    tx_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rx_valid) begin
        rx_cnt++;
        if (rx_prev) viol++;
      end
      if (tx_req) begin
        k = tx_cnt - tx_base;
        if (k > 2) k = 2;
        if (k < 0) k = 0;
        tx_data = tx_bytes[k];
        tx_cnt++;
        if (tx_prev) viol++;
      end
      if (rx_valid && tx_req) viol++;
      if (sda_oe) oe_cnt++;
      rx_prev = rx_valid;
      tx_prev = tx_req;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_cond();
    sda_m = 1'b0; wait_clk(8);
    scl_m = 1'b0; wait_clk(8);
  endtask

  task automatic stop_cond();
    sda_m = 1'b0; wait_clk(8);
    scl_m = 1'b1; wait_clk(8);
    sda_m = 1'b1; wait_clk(8);
  endtask

  task automatic rstart_cond();
    sda_m = 1'b1; wait_clk(8);
    scl_m = 1'b1; wait_clk(8);
    sda_m = 1'b0; wait_clk(8);
    scl_m = 1'b0; wait_clk(8);
  endtask

  task automatic send_bit(input logic b, output logic got);
    sda_m = b;    wait_clk(8);
    scl_m = 1'b1; wait_clk(8);
    got = sda_line;
    wait_clk(8);
    scl_m = 1'b0; wait_clk(8);
  endtask

  task automatic byte_cycle(input logic [7:0] drv, input logic mack,
                            output logic [7:0] got, output logic ack);
    logic g;
    for (int i = 7; i >= 0; i--) begin
      send_bit(drv[i], g);
      got[i] = g;
    end
    send_bit(mack, ack);
  endtask

  task automatic run_xfer(input logic [6:0] addr, input logic rw, input int n,
                          input logic [2:0][7:0] b, input int exp_rx,
                          input int exp_tx, input logic [2:0] exp_st);
    logic       matched, ack;
    logic [7:0] got;
    int         rx0, tx0, oe0;
    matched  = (addr == SLAVE);
    rx0      = rx_cnt;
    tx0      = tx_cnt;
    oe0      = oe_cnt;
    tx_base  = tx_cnt;
    tx_bytes = b;
    start_cond();
    byte_cycle({addr, rw}, 1'b1, got, ack);
    check("addr_ack", ack, matched ? ACK : NACK);
    for (int i = 0; i < n; i++) begin
      if (rw == WRITE) begin
        byte_cycle(b[i], 1'b1, got, ack);
        check("wr_ack", ack, matched ? ACK : NACK);
      end else begin
        byte_cycle(8'hFF, (i == n - 1) ? NACK : ACK, got, ack);
        check("rd_byte", got, matched ? b[i] : 8'hFF);
      end
    end
    check("state_pre_stop", state, exp_st);
    check("addressed_pre_stop", addressed, matched);
    if (!matched) check("oe_quiet", oe_cnt - oe0, 0);
    stop_cond();
    check("state_after_stop", state, IDLE);
    check("addressed_after_stop", addressed, 1'b0);
    check("rx_pulses", rx_cnt - rx0, exp_rx);
    check("tx_pulses", tx_cnt - tx0, exp_tx);
    if (exp_rx > 0) exp_rx_data = b[n-1];
    check("rx_data", rx_data, exp_rx_data);
    $display("xfer addr=%02h rw=%0d n=%0d bytes=%06h rx=%0d tx=%0d errors_so_far=%0d",
             addr, rw, n, b, rx_cnt - rx0, tx_cnt - tx0, errors);
  endtask

  typedef struct {
    logic [6:0]      addr;
    logic            rw;
    int              n;
    logic [2:0][7:0] b;
    int              exp_rx;
    int              exp_tx;
    logic [2:0]      exp_st;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic       ack, g, matched, rw;
    logic [7:0] got;
    logic [6:0] addr;
    logic [2:0][7:0] rb;
    int         rx0, oe0, n;

    vecs[0] = '{7'h52, WRITE, 1, {8'h00, 8'h00, 8'h3C}, 1, 0, 3'd3};
    vecs[1] = '{7'h11, WRITE, 1, {8'h00, 8'h00, 8'hFF}, 0, 0, 3'd7};
    vecs[2] = '{7'h52, READ,  2, {8'h00, 8'h5A, 8'hA5}, 0, 2, 3'd7};
    vecs[3] = '{7'h52, WRITE, 3, {8'h81, 8'hFF, 8'h00}, 3, 0, 3'd3};
    vecs[4] = '{7'h29, READ,  1, {8'h00, 8'h00, 8'h77}, 0, 0, 3'd7};
    vecs[5] = '{7'h53, WRITE, 1, {8'h00, 8'h00, 8'h12}, 0, 0, 3'd7};
    vecs[6] = '{7'h52, READ,  1, {8'h00, 8'h00, 8'h80}, 0, 1, 3'd7};

    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    wait_clk(5);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_pulses", {rx_valid, tx_req}, 2'b00);
    check("rst_addressed", addressed, 1'b0);
    check("rst_state", state, IDLE);
    rst = 1'b0;
    wait_clk(10);

    for (int v = 0; v < 7; v++)
      run_xfer(vecs[v].addr, vecs[v].rw, vecs[v].n, vecs[v].b,
               vecs[v].exp_rx, vecs[v].exp_tx, vecs[v].exp_st);

    // Repeated START after 4 data bits discards the partial byte.
    rx0 = rx_cnt;
    start_cond();
    byte_cycle({SLAVE, WRITE}, 1'b1, got, ack);
    for (int i = 0; i < 4; i++) send_bit(i[0], g);
    rstart_cond();
    check("rs_state", state, ADDR);
    check("rs_addressed", addressed, 1'b0);
    check("rs_sda_oe", sda_oe, 1'b0);
    byte_cycle({SLAVE, WRITE}, 1'b1, got, ack);
    check("rs_addr_ack", ack, ACK);
    byte_cycle(8'h81, 1'b1, got, ack);
    check("rs_data_ack", ack, ACK);
    stop_cond();
    check("rs_rx_pulses", rx_cnt - rx0, 1);
    check("rs_rx_data", rx_data, 8'h81);
    exp_rx_data = 8'h81;
    $display("seq repeated_start rx=%0d rx_data=%02h", rx_cnt - rx0, rx_data);

    // STOP after 5 bits of a write byte.
    rx0 = rx_cnt;
    start_cond();
    byte_cycle({SLAVE, WRITE}, 1'b1, got, ack);
    for (int i = 0; i < 5; i++) send_bit(1'b1, g);
    check("ps_state_mid", state, WR_DATA);
    check("ps_addressed_mid", addressed, 1'b1);
    stop_cond();
    check("ps_state", state, IDLE);
    check("ps_addressed", addressed, 1'b0);
    check("ps_rx_data", rx_data, exp_rx_data);
    check("ps_rx_pulses", rx_cnt - rx0, 0);
    $display("seq partial_stop state=%0d rx_data=%02h", state, rx_data);

    // Reset while the target is pulling SDA low mid read byte.
    tx_base  = tx_cnt;
    tx_bytes = {8'h00, 8'h00, 8'h00};
    start_cond();
    byte_cycle({SLAVE, READ}, 1'b1, got, ack);
    for (int i = 0; i < 3; i++) send_bit(1'b1, g);
    check("rr_sda_oe_before", sda_oe, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rr_sda_oe", sda_oe, 1'b0);
    check("rr_state", state, IDLE);
    check("rr_addressed", addressed, 1'b0);
    check("rr_rx_data", rx_data, 8'h00);
    exp_rx_data = 8'h00;
    wait_clk(3);
    rst = 1'b0;
    oe0 = oe_cnt;
    for (int i = 0; i < 14; i++) send_bit(SLAVE[i % 7], g);
    check("rr_state_quiet", state, IDLE);
    check("rr_oe_quiet", oe_cnt - oe0, 0);
    stop_cond();
    $display("seq reset_mid_read state=%0d sda_oe=%0d", state, sda_oe);

    // Randomized transfers against the transaction-level model.
    for (int t = 0; t < 12; t++) begin
      addr    = ($urandom_range(0, 1) == 1) ? SLAVE : 7'($urandom);
      rw      = 1'($urandom);
      n       = $urandom_range(1, 3);
      rb      = 24'($urandom);
      matched = (addr == SLAVE);
      run_xfer(addr, rw, n, rb,
               (matched && rw == WRITE) ? n : 0,
               (matched && rw == READ)  ? n : 0,
               (matched && rw == WRITE) ? 3'(WR_DATA) : 3'(WAIT_STOP));
    end

    check("pulse_rules", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
